// File: rtl/address_counter.sv
// ---------------------------------------------------------------------------
// address_counter
// Sequential raw test-address source for one march element. Sweeps the
// address up (0..ADDR_MAX) or down (ADDR_MAX..0), one address per accepted
// step, flags the end address and pulses done when the element completes.
// Feeds address_generator directly (tas_out -> tas_in, updwn_out -> updwn_in).
// ---------------------------------------------------------------------------
module address_counter #(
   parameter int              tasw     = 8,
   parameter logic [tasw-1:0] ADDR_MAX = {tasw{1'b1}}
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_in,
   input  logic            updwn_in,
   input  logic            step_in,
   input  logic            abort_in,
   output logic [tasw-1:0] tas_out,
   output logic            updwn_out,
   output logic            busy_out,
   output logic            last_out,
   output logic            done_out
);

   // Direction encoding shared with address_generator
   localparam logic ADDR_UP   = 1'b0;
   localparam logic ADDR_DOWN = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [tasw-1:0]   tas_r;
   logic [tasw-1:0]   tas_s;
   logic              updwn_r;
   logic              updwn_s;
   logic [tasw-1:0]   end_addr_s;
   logic              last_s;

   // Sweep end address depends on the latched direction
   assign end_addr_s = (updwn_r == ADDR_DOWN) ? {tasw{1'b0}} : ADDR_MAX;

   // The last address is decoded straight from the registers so it carries no extra latency
   assign last_s = (state_r == ST_RUN) && (tas_r == end_addr_s);

   // State, address and direction registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         tas_r   <= {tasw{1'b0}};
         updwn_r <= ADDR_UP;
      end else begin
         state_r <= state_s;
         tas_r   <= tas_s;
         updwn_r <= updwn_s;
      end
   end

   // Next-state logic: start reload, abort > step > hold in RUN, one-cycle DONE
   always_comb begin
      state_s = state_r;
      tas_s   = tas_r;
      updwn_s = updwn_r;
      case (state_r)
         ST_IDLE: begin
            if (start_in) begin
               state_s = ST_RUN;
               updwn_s = updwn_in;
               tas_s   = (updwn_in == ADDR_DOWN) ? ADDR_MAX : {tasw{1'b0}};
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (abort_in) begin
               state_s = ST_IDLE;
               tas_s   = {tasw{1'b0}};
            end else if (step_in) begin
               if (last_s) begin
                  // End address reached: hold it and report completion
                  state_s = ST_DONE;
               end else if (updwn_r == ADDR_DOWN) begin
                  tas_s = tas_r - tasw'(1'b1);
               end else begin
                  tas_s = tas_r + tasw'(1'b1);
               end
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (abort_in) begin
               // Pulse already given; just return to idle
               state_s = ST_IDLE;
               tas_s   = {tasw{1'b0}};
            end else if (start_in) begin
               // Back-to-back element without an idle gap
               state_s = ST_RUN;
               updwn_s = updwn_in;
               tas_s   = (updwn_in == ADDR_DOWN) ? ADDR_MAX : {tasw{1'b0}};
            end else begin
               state_s = ST_IDLE;
               tas_s   = {tasw{1'b0}};
            end
         end
         default: begin
            state_s = ST_IDLE;
            tas_s   = {tasw{1'b0}};
            updwn_s = ADDR_UP;
         end
      endcase
   end

   assign tas_out   = tas_r;
   assign updwn_out = updwn_r;
   assign busy_out  = (state_r == ST_RUN);
   assign last_out  = last_s;
   assign done_out  = (state_r == ST_DONE);

endmodule

// File: tb/tb_address_counter.sv
// ---------------------------------------------------------------------------
// tb_address_counter
// Directed stimulus against a sweep-level model of the address counter, with
// a per-cycle compare process and hand-computed checks at key points. A second
// instance built with ADDR_MAX=0 covers the single-address element.
// ---------------------------------------------------------------------------
module tb_address_counter;

   logic       clk;
   logic       rst_n;
   logic       start_in, updwn_in, step_in, abort_in;
   logic [7:0] tas_out;
   logic       updwn_out, busy_out, last_out, done_out;

   logic       start0, updwn0, step0;
   logic [7:0] tas0;
   logic       updwn0_out, busy0, last0, done0;

   int n_cmp = 0;
   int n_err = 0;
   bit mon_en = 1'b0;

   address_counter #(.tasw(8)) dut (
      .clk(clk), .rst_n(rst_n), .start_in(start_in), .updwn_in(updwn_in),
      .step_in(step_in), .abort_in(abort_in), .tas_out(tas_out),
      .updwn_out(updwn_out), .busy_out(busy_out), .last_out(last_out),
      .done_out(done_out)
   );

   address_counter #(.tasw(8), .ADDR_MAX(8'd0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start_in(start0), .updwn_in(updwn0),
      .step_in(step0), .abort_in(1'b0), .tas_out(tas0),
      .updwn_out(updwn0_out), .busy_out(busy0), .last_out(last0),
      .done_out(done0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---- sweep-level model: "sweeping" flag, current address, pulse flag ----
   bit m_sweeping;
   bit m_pulse;
   bit m_down;
   int m_addr;

   function automatic int sweep_end(bit down);
      return down ? 0 : 255;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sweeping <= 1'b0; m_pulse <= 1'b0; m_down <= 1'b0; m_addr <= 0;
      end else if (m_sweeping) begin
         if (abort_in) begin
            m_sweeping <= 1'b0; m_addr <= 0;
         end else if (step_in) begin
            if (m_addr == sweep_end(m_down)) begin
               m_sweeping <= 1'b0; m_pulse <= 1'b1;
            end else begin
               m_addr <= m_down ? m_addr - 1 : m_addr + 1;
            end
         end
      end else if (start_in && !(m_pulse && abort_in)) begin
         m_sweeping <= 1'b1; m_pulse <= 1'b0; m_down <= updwn_in;
         m_addr <= updwn_in ? 255 : 0;
      end else begin
         m_pulse <= 1'b0; m_addr <= 0;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare of every output against the model
   always @(negedge clk) begin
      if (mon_en) begin
         chk("tas",   int'(tas_out),   m_addr);
         chk("updwn", int'(updwn_out), int'(m_down));
         chk("busy",  int'(busy_out),  int'(m_sweeping));
         chk("last",  int'(last_out),  int'(m_sweeping && m_addr == sweep_end(m_down)));
         chk("done",  int'(done_out),  int'(m_pulse));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int n_last;
   int n_done;
   int n_steps;

   initial begin
      rst_n = 1'b0; start_in = 1'b0; updwn_in = 1'b0; step_in = 1'b0; abort_in = 1'b0;
      start0 = 1'b0; updwn0 = 1'b0; step0 = 1'b0;
      repeat (2) @(posedge clk);
      mon_en = 1'b1;
      #1 rst_n = 1'b1;

      // 1: reset values
      tick();
      chk("rst_tas", int'(tas_out), 0);
      chk("rst_updwn", int'(updwn_out), 0);
      chk("rst_busy", int'(busy_out), 0);
      chk("rst_last_done", int'({last_out, done_out}), 0);

      // 2: up sweep, step every cycle
      start_in = 1'b1; updwn_in = 1'b0;
      tick();
      start_in = 1'b0;
      chk("up_first", int'({busy_out, tas_out}), 32'h100);
      step_in = 1'b1;
      n_last = 0; n_steps = 0;
      for (int i = 0; i < 300; i++) begin
         if (last_out) n_last++;
         tick();
         n_steps++;
         if (done_out) break;
      end
      chk("up_steps", n_steps, 256);
      chk("up_last_cnt", n_last, 1);
      chk("up_done_tas", int'(tas_out), 8'hFF);
      step_in = 1'b0;
      tick();
      chk("up_after", int'({done_out, busy_out, tas_out}), 0);

      // 3: down sweep, step on alternate cycles
      start_in = 1'b1; updwn_in = 1'b1;
      tick();
      start_in = 1'b0; updwn_in = 1'b0;
      chk("dn_first", int'({updwn_out, tas_out}), 32'h1FF);
      n_last = 0; n_done = 0;
      for (int i = 0; i < 520; i++) begin
         step_in = (i % 2 == 0);
         tick();
         if (last_out) n_last++;
         if (done_out) n_done++;
         if (i == 1) chk("dn_gap_hold", int'(tas_out), 8'hFE);
      end
      step_in = 1'b0;
      chk("dn_last_cnt", n_last, 2);
      chk("dn_done_cnt", n_done, 1);

      // 4: abort with step at 0x40
      start_in = 1'b1;
      tick();
      start_in = 1'b0; step_in = 1'b1;
      repeat (8'h40) tick();
      chk("ab_at", int'(tas_out), 8'h40);
      abort_in = 1'b1;
      tick();
      abort_in = 1'b0; step_in = 1'b0;
      chk("ab_next", int'({done_out, busy_out, tas_out}), 0);
      tick();
      chk("ab_no_done", int'(done_out), 0);

      // 5: back-to-back start in DONE with direction down
      start_in = 1'b1; updwn_in = 1'b0;
      tick();
      start_in = 1'b0; step_in = 1'b1;
      repeat (256) tick();
      chk("b2b_done", int'(done_out), 1);
      step_in = 1'b0; start_in = 1'b1; updwn_in = 1'b1;
      tick();
      start_in = 1'b0; updwn_in = 1'b0;
      chk("b2b_reload", int'({busy_out, updwn_out, tas_out}), 32'h3FF);
      abort_in = 1'b1;
      tick();
      abort_in = 1'b0;

      // 6: async reset between edges at 0x80
      start_in = 1'b1;
      tick();
      start_in = 1'b0; step_in = 1'b1;
      repeat (8'h80) tick();
      step_in = 1'b0;
      chk("rs_at", int'(tas_out), 8'h80);
      #2 rst_n = 1'b0;
      #1;
      chk("rs_async", int'({done_out, last_out, busy_out, updwn_out, tas_out}), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // ADDR_MAX = 0 build: one address, one step completes the element
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      chk("m0_run", int'({busy0, last0, tas0}), 32'h300);
      step0 = 1'b1;
      tick();
      step0 = 1'b0;
      chk("m0_done", int'({done0, busy0}), 2);
      tick();
      chk("m0_idle", int'({done0, busy0, tas0}), 0);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
